// File: rtl/seq_mag_comp.sv
// Bit-serial, MSB-first magnitude comparator with start/busy/done handshake.
// One operand bit pair is examined per enabled clock; results hold until the next accepted start.
module seq_mag_comp #(
    parameter int WIDTH      = 8,
    parameter bit SIGNED_EN  = 1'b1,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             gt,
    output logic             eq
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             lt_q, lt_d;
    logic             gt_q, gt_d;
    logic             eq_q, eq_d;
    logic             done_q, done_d;
    // First decision seen so far; only consulted in constant-latency mode.
    logic             dec_lt_q, dec_lt_d;
    logic             dec_gt_q, dec_gt_d;

    logic bit_a, bit_b, msb_signed, bit_lt, bit_gt, decided, fin_lt, fin_gt;

    // NOTE: every state element uses non-blocking assignments so all registers
    // update together from the values present before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            idx_q    <= '0;
            lt_q     <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            done_q   <= 1'b0;
            dec_lt_q <= 1'b0;
            dec_gt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sgn_q    <= sgn_d;
            idx_q    <= idx_d;
            lt_q     <= lt_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            done_q   <= done_d;
            dec_lt_q <= dec_lt_d;
            dec_gt_q <= dec_gt_d;
        end
    end

    // The sign bit carries inverted weight in two's complement.
    assign bit_a      = a_q[idx_q];
    assign bit_b      = b_q[idx_q];
    assign msb_signed = sgn_q && (idx_q == IDX_TOP);
    assign bit_gt     = msb_signed ? (!bit_a && bit_b) : (bit_a && !bit_b);
    assign bit_lt     = msb_signed ? (bit_a && !bit_b) : (!bit_a && bit_b);
    assign decided    = dec_lt_q || dec_gt_q;
    assign fin_lt     = dec_lt_q || (!decided && bit_lt);
    assign fin_gt     = dec_gt_q || (!decided && bit_gt);

    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        idx_d    = idx_q;
        lt_d     = lt_q;
        gt_d     = gt_q;
        eq_d     = eq_q;
        dec_lt_d = dec_lt_q;
        dec_gt_d = dec_gt_q;
        done_d   = 1'b0;

        if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d  = CMP;
                        a_d      = a;
                        b_d      = b;
                        sgn_d    = signed_mode && SIGNED_EN;
                        idx_d    = IDX_TOP;
                        lt_d     = 1'b0;
                        gt_d     = 1'b0;
                        eq_d     = 1'b0;
                        dec_lt_d = 1'b0;
                        dec_gt_d = 1'b0;
                    end
                end
                CMP: begin
                    if (EARLY_EXIT) begin
                        if (bit_lt || bit_gt) begin
                            lt_d    = bit_lt;
                            gt_d    = bit_gt;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else if (idx_q == '0) begin
                            eq_d    = 1'b1;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end else begin
                        dec_lt_d = fin_lt;
                        dec_gt_d = fin_gt;
                        if (idx_q == '0) begin
                            lt_d    = fin_lt;
                            gt_d    = fin_gt;
                            eq_d    = !(fin_lt || fin_gt);
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q - IDX_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign busy = (state_q == CMP);
    assign done = done_q;
    assign lt   = lt_q;
    assign gt   = gt_q;
    assign eq   = eq_q;

endmodule
